// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter: Q12.12 width,
// saturation values, the flush/run state and the per-request return tag.
package div_arb_pkg;

  localparam int DW = 24;

  localparam logic [DW-1:0] Q_MAX = 24'h7FFFFF;
  localparam logic [DW-1:0] Q_MIN = 24'h800000;

  // Tag id field is sized for the largest supported requester count (8).
  localparam int ID_W = 3;

  typedef enum logic {
    FLUSH,
    RUN
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;   // owning requester
    logic            dbz;  // divisor was zero
    logic            neg;  // dividend sign, selects the saturation value
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // Saturated quotient for a divide by zero, signed by the dividend.
  function automatic logic [DW-1:0] sat_value(input logic neg);
    return neg ? Q_MIN : Q_MAX;
  endfunction

endpackage

// File: rtl/div_tag_fifo.sv
// Synchronous tag FIFO: one write and one read port, occupancy count,
// first-word fall-through read data. Push when full and pop when empty are ignored.
module div_tag_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write.
  // NOTE: the array has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency Q12.12 divider among N_REQ
// requesters. Quotients are routed back in order through a tag FIFO; divides
// by zero are saturated, and a post-reset flush discards in-flight results.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DIV_LATENCY = 28,
  parameter int TAG_DEPTH   = 32
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*DW-1:0]   req_dividend,
  input  logic [N_REQ*DW-1:0]   req_divisor,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [DW-1:0]         resp_result,
  output logic                  resp_dbz,
  output logic                  div_dividend_tvalid,
  output logic                  div_divisor_tvalid,
  output logic [DW-1:0]         div_dividend,
  output logic [DW-1:0]         div_divisor,
  input  logic                  div_tvalid,
  input  logic [DW-1:0]         div_result,
  output logic                  busy,
  output logic                  err_orphan
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(DIV_LATENCY + 1);
  localparam int FC_W  = $clog2(TAG_DEPTH) + 1;

  state_e            state;
  logic [CNT_W-1:0]  flush_cnt;
  logic [IDX_W-1:0]  rr_ptr;
  logic              div_valid_q;

  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              running;
  logic              accept;
  logic              pop;
  logic              orphan;
  logic [DW-1:0]     sel_dividend;
  logic [DW-1:0]     sel_divisor;

  tag_t              push_tag;
  tag_t              head_tag;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FC_W-1:0]   fifo_count;

  // Round-robin search upward from the entry after the last winner, with wrap.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = IDX_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign running   = (state == RUN);
  assign req_ready = (running && !fifo_full) ? grant : '0;
  assign accept    = running && !fifo_full && gnt_any;

  assign sel_dividend = req_dividend[gnt_idx*DW +: DW];
  assign sel_divisor  = req_divisor[gnt_idx*DW +: DW];

  // Return tag for the accepted request.
  always_comb begin
    push_tag.id  = ID_W'(gnt_idx);
    push_tag.dbz = (sel_divisor == '0);
    push_tag.neg = sel_dividend[DW-1];
  end

  // Results are only matched to tags in RUN; during FLUSH the divider output is ignored.
  assign pop    = running && div_tvalid && !fifo_empty;
  assign orphan = running && div_tvalid && fifo_empty;

  div_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (sysclk),
    .rst   (rst),
    .push  (accept),
    .wdata (push_tag),
    .pop   (pop),
    .rdata (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Flush sequencing, divider issue, response registers and the sticky orphan flag.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state        <= FLUSH;
      flush_cnt    <= CNT_W'(DIV_LATENCY);
      rr_ptr       <= IDX_W'(N_REQ - 1);
      div_valid_q  <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      resp_valid   <= '0;
      resp_result  <= '0;
      resp_dbz     <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      case (state)
        FLUSH: begin
          flush_cnt <= flush_cnt - CNT_W'(1);
          if (flush_cnt <= CNT_W'(1)) state <= RUN;
        end
        RUN:     state <= RUN;
        default: state <= FLUSH;
      endcase

      div_valid_q <= accept;
      if (accept) begin
        rr_ptr       <= gnt_idx;
        div_dividend <= sel_dividend;
        div_divisor  <= sel_divisor;
      end

      resp_valid <= '0;
      resp_dbz   <= 1'b0;
      if (pop) begin
        resp_valid  <= N_REQ'(1) << head_tag.id;
        resp_result <= head_tag.dbz ? sat_value(head_tag.neg) : div_result;
        resp_dbz    <= head_tag.dbz;
      end

      if (orphan) err_orphan <= 1'b1;
    end
  end

  assign div_dividend_tvalid = div_valid_q;
  assign div_divisor_tvalid  = div_valid_q;
  assign busy                = (state == FLUSH) || (fifo_count != '0);

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one radix2_div instance (24-bit signed Q12.12 divide, fixed latency, no backpressure) between N_REQ requesters, e.g. per-axis ray-slab reciprocal/t-value units.
- Round-robin arbitration issues at most one divide per cycle.
- An in-order tag FIFO routes each quotient back to its requester.
- Adds divide-by-zero saturation and a post-reset flush so divider results in flight across a reset are discarded.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DIV_LATENCY, 28, cycles from divider input valid to divider tvalid; must match the generated divider core.
- TAG_DEPTH, 32, tag FIFO entries; power of two, >= DIV_LATENCY+2.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; a request transfers when valid&&ready.
- req_dividend  in  N_REQ*24  packed signed Q12.12 dividends; requester i uses [24i+23:24i].
- req_divisor  in  N_REQ*24  packed signed Q12.12 divisors, same packing.
- resp_valid  out  N_REQ  one-cycle pulse to the owning requester; no backpressure, so the consumer must accept it.
- resp_result  out  24  shared signed Q12.12 result bus, valid with any resp_valid bit.
- resp_dbz  out  1  the result was produced by divide-by-zero saturation.
- div_dividend_tvalid  out  1  to radix2_div.
- div_divisor_tvalid  out  1  to radix2_div; identical to div_dividend_tvalid.
- div_dividend  out  24  to radix2_div.
- div_divisor  out  24  to radix2_div.
- div_tvalid  in  1  from radix2_div.
- div_result  in  24  from radix2_div.
- busy  out  1  flushing, or at least one divide outstanding.
- err_orphan  out  1  sticky: div_tvalid arrived in RUN with the tag FIFO empty; cleared only by rst.

Behaviour:
- Reset and flush:
  - rst forces state FLUSH and flush counter = DIV_LATENCY.
  - rst zeroes all registered outputs, the RR pointer (pointer = N_REQ-1, so requester 0 has first priority), FIFO pointers, FIFO count and err_orphan.
  - rst asserted mid-operation drops all outstanding tags; no response is ever produced for them.
- States:
  - FLUSH: req_ready=0; div_tvalid is ignored. The counter decrements each cycle; on reaching 0 the state goes to RUN.
  - RUN: normal operation; leaves only via rst.
- Arbitration (combinational):
  - Grant goes to the first asserted req_valid searching upward from pointer+1 with wrap-around.
  - req_ready[i] = RUN && grant[i] && fifo_count < TAG_DEPTH. At most one bit is set.
  - On acceptance the pointer becomes the granted index. Holding valid without acceptance does not move the pointer.
- Issue: on the acceptance cycle T, register the operands onto div_* with both tvalids high at T+1; otherwise both tvalids are 0.
- Tag push: at T, push {id, dbz}. id is the requester index ($clog2(N_REQ) bits); dbz = (divisor == 0).
- Return:
  - On div_tvalid in RUN with the FIFO non-empty, pop the head.
  - At the next cycle, pulse resp_valid[id] and drive resp_result and resp_dbz.
  - Total request-to-response latency = DIV_LATENCY+2 cycles.
- Divide-by-zero result: the divider output is replaced by 24'h7FFFFF for dividend >= 0, else 24'h800000. The dividend sign bit is stored in the tag alongside dbz.
- Simultaneous push and pop in one cycle: fifo_count is unchanged and both operations take effect.
- Outputs when idle: resp_valid=0; resp_result holds its last value; resp_dbz=0.
- Orphan return (div_tvalid in RUN with the FIFO empty): set err_orphan and drop the result.
- busy = FLUSH || fifo_count != 0.

Decomposition:
- Package div_arb_pkg:
  - Q12.12 width constant DW=24.
  - Saturation constants Q_MAX=24'h7FFFFF and Q_MIN=24'h800000.
  - State enum {FLUSH, RUN}.
  - Tag struct {id, dbz, neg}.
- Sub-module div_tag_fifo: synchronous FIFO (push, pop, full, empty, count), parameterised on depth and width.
- The radix2_div instance is a sibling at the parent level and is not instantiated inside this block.

Test Plan:
- Single op: after flush, req 0 sends 6.0/2.0 (24'h006000 / 24'h002000) -> resp_valid[0] exactly DIV_LATENCY+2 cycles after acceptance, resp_result=24'h003000, resp_dbz=0.
- Fairness: all 4 requesters hold valid for 8 accepts -> grant order 0,1,2,3,0,1,2,3; responses return in the same order to the matching resp_valid bits.
- Divide by zero: req 2 sends 24'h004000/0 -> resp_valid[2], resp_result=24'h7FFFFF, resp_dbz=1; with dividend 24'hFFC000 -> resp_result=24'h800000.
- Full FIFO: with the divider model latency raised to TAG_DEPTH+4, issue continuously -> req_ready drops after 32 outstanding and recovers on the first pop; no results are lost.
- Reset mid-flight: accept 5 ops, assert rst for 1 cycle -> no resp_valid pulses appear, req_ready stays 0 for DIV_LATENCY cycles, err_orphan stays 0, and new ops then complete correctly.
- Orphan: inject div_tvalid in RUN with the FIFO empty -> err_orphan=1 and sticky until rst; no resp_valid.
